// File: rtl/card_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_game_pkg
//  Description : Shared types and constants for the 4x4 card-matching game.
//                Holds the game state encoding, the base card layout and the
//                helper that maps a board position to its card value under
//                the per-game seed.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_game_pkg;

    localparam int unsigned GRID      = 4;
    localparam int unsigned NUM_POS   = GRID * GRID;
    localparam int unsigned NUM_PAIRS = 8;

    typedef logic [2:0] card_val_t;
    typedef logic [3:0] pos_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK1 = 3'd1,
        PICK2 = 3'd2,
        SHOW  = 3'd3,
        WIN   = 3'd4
    } state_e;

    // Base layout. Each value 0..7 appears exactly twice.
    localparam card_val_t LAYOUT [NUM_POS] = '{
        3'd3, 3'd5, 3'd0, 3'd7,
        3'd1, 3'd6, 3'd2, 3'd4,
        3'd6, 3'd0, 3'd4, 3'd1,
        3'd7, 3'd3, 3'd5, 3'd2
    };

    // XOR with the seed permutes positions, so the value multiset is kept.
    function automatic card_val_t card_value(input pos_t pos, input pos_t seed);
        return LAYOUT[pos ^ seed];
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_game_if.sv
`default_nettype none
// ============================================================================
//  Module      : card_game_if
//  Description : Bundle between button/frame logic plus renderers (master)
//                and the game controller (slave).
//                master drives : frame_tick, btn_up/down/left/right/sel, qpos
//                slave drives  : qval, cursor, face_up, matched, pairs,
//                                misses, playing, win
//  Revision    : 1.0 - initial release
// ============================================================================
interface card_game_if;
    import card_game_pkg::*;

    logic                 frame_tick;
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_sel;
    pos_t                 qpos;
    card_val_t            qval;
    pos_t                 cursor;
    logic [NUM_POS-1:0]   face_up;
    logic [NUM_POS-1:0]   matched;
    logic [3:0]           pairs;
    logic [7:0]           misses;
    logic                 playing;
    logic                 win;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel, qpos,
        input  qval, cursor, face_up, matched, pairs, misses, playing, win
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel, qpos,
        output qval, cursor, face_up, matched, pairs, misses, playing, win
    );

endinterface
`default_nettype wire

// File: rtl/card_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : card_cursor
//  Description : Board cursor register with row/column wrap-around.
//                Ports:
//                  clk, rst_n  - clock, synchronous active-low reset
//                  clr_i       - return cursor to position 0
//                  en_i        - allow movement this cycle
//                  up_i/down_i/left_i/right_i - direction pulses,
//                                priority up > down > left > right
//                  cursor_o    - {row[1:0], col[1:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module card_cursor
    import card_game_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    input  wire logic up_i,
    input  wire logic down_i,
    input  wire logic left_i,
    input  wire logic right_i,
    output pos_t      cursor_o
);

    localparam int unsigned        c_rc_w = $clog2(GRID);
    localparam logic [c_rc_w-1:0]  c_step = 1;

    logic [c_rc_w-1:0] row_q, row_d;
    logic [c_rc_w-1:0] col_q, col_d;

    // GRID is a power of two, so plain modular add/subtract gives the wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (up_i) begin
                row_d = row_q - c_step;
            end else if (down_i) begin
                row_d = row_q + c_step;
            end else if (left_i) begin
                col_d = col_q - c_step;
            end else if (right_i) begin
                col_d = col_q + c_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign cursor_o = {row_q, col_q};

endmodule
`default_nettype wire

// File: rtl/card_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : card_game_ctrl
//  Description : Turn sequencer and board-state owner for the 4x4 card game.
//                Ports:
//                  clk    - system/pixel clock
//                  rst_n  - synchronous active-low reset
//                  bus    - card_game_if.slave: buttons, frame tick and
//                           renderer query in; qval, cursor, masks,
//                           counters and playing/win flags out
//                Parameter SHOW_FRAMES (1..255): frame ticks a revealed
//                pair stays visible before it is resolved.
//                Build option CARD_GAME_MISS_CNT_EN: when defined, a
//                saturating 8-bit miss counter is built; otherwise misses
//                reads as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_game_ctrl
    import card_game_pkg::*;
#(
    parameter int unsigned SHOW_FRAMES = 60
)
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    card_game_if.slave bus
);

    localparam logic [7:0] c_show_frames = 8'(SHOW_FRAMES);
    localparam logic [3:0] c_last_pair   = 4'(NUM_PAIRS - 1);

    state_e               state_q, state_d;
    pos_t                 seed_cnt_q;
    pos_t                 seed_q, seed_d;
    pos_t                 first_q, first_d;
    pos_t                 second_q, second_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic [NUM_POS-1:0]   face_up_q, face_up_d;
    logic [NUM_POS-1:0]   matched_q, matched_d;
    logic [3:0]           pairs_q, pairs_d;
    card_val_t            qval_q;
    logic                 playing_q;
    logic                 win_q;

    pos_t                 w_cursor;
    logic                 w_selectable;
    logic                 w_pair_equal;
    logic [7:0]           w_fcnt_inc;
    logic                 w_miss_inc;
    logic                 w_miss_clr;
    logic                 w_cur_en;
    logic                 w_cur_clr;

    // ------------------------------------------------------------------
    // Cursor. A select has priority over any direction pressed with it,
    // so movement is suppressed whenever btn_sel is high.
    // ------------------------------------------------------------------
    assign w_cur_en  = ((state_q == PICK1) || (state_q == PICK2)) && !bus.btn_sel;
    assign w_cur_clr = (state_q == WIN) && bus.btn_sel;

    card_cursor u_cursor (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_cur_clr),
        .en_i     (w_cur_en),
        .up_i     (bus.btn_up),
        .down_i   (bus.btn_down),
        .left_i   (bus.btn_left),
        .right_i  (bus.btn_right),
        .cursor_o (w_cursor)
    );

    assign w_selectable = !face_up_q[w_cursor] && !matched_q[w_cursor];
    assign w_pair_equal = (card_value(first_q, seed_q) == card_value(second_q, seed_q));
    assign w_fcnt_inc   = fcnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        first_d    = first_q;
        second_d   = second_q;
        fcnt_d     = fcnt_q;
        face_up_d  = face_up_q;
        matched_d  = matched_q;
        pairs_d    = pairs_q;
        w_miss_inc = 1'b0;
        w_miss_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.btn_sel) begin
                    seed_d  = seed_cnt_q;
                    state_d = PICK1;
                end
            end

            PICK1: begin
                if (bus.btn_sel && w_selectable) begin
                    face_up_d[w_cursor] = 1'b1;
                    first_d             = w_cursor;
                    state_d             = PICK2;
                end
            end

            PICK2: begin
                // Re-selecting the first card fails w_selectable because
                // it is already face up.
                if (bus.btn_sel && w_selectable) begin
                    face_up_d[w_cursor] = 1'b1;
                    second_d            = w_cursor;
                    fcnt_d              = '0;
                    state_d             = SHOW;
                end
            end

            SHOW: begin
                if (bus.frame_tick) begin
                    fcnt_d = w_fcnt_inc;
                    if (w_fcnt_inc == c_show_frames) begin
                        face_up_d[first_q]  = 1'b0;
                        face_up_d[second_q] = 1'b0;
                        if (w_pair_equal) begin
                            matched_d[first_q]  = 1'b1;
                            matched_d[second_q] = 1'b1;
                            pairs_d             = pairs_q + 4'd1;
                            state_d = (pairs_q == c_last_pair) ? WIN : PICK1;
                        end else begin
                            w_miss_inc = 1'b1;
                            state_d    = PICK1;
                        end
                    end
                end
            end

            WIN: begin
                if (bus.btn_sel) begin
                    face_up_d  = '0;
                    matched_d  = '0;
                    pairs_d    = '0;
                    w_miss_clr = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and board registers. playing/win are registered from the
    // next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seed_cnt_q <= '0;
            seed_q     <= '0;
            first_q    <= '0;
            second_q   <= '0;
            fcnt_q     <= '0;
            face_up_q  <= '0;
            matched_q  <= '0;
            pairs_q    <= '0;
            qval_q     <= '0;
            playing_q  <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_q + 4'd1;
            seed_q     <= seed_d;
            first_q    <= first_d;
            second_q   <= second_d;
            fcnt_q     <= fcnt_d;
            face_up_q  <= face_up_d;
            matched_q  <= matched_d;
            pairs_q    <= pairs_d;
            qval_q     <= card_value(bus.qpos, seed_q);
            playing_q  <= (state_d == PICK1) || (state_d == PICK2) || (state_d == SHOW);
            win_q      <= (state_d == WIN);
        end
    end

    // ------------------------------------------------------------------
    // Miss counter
    // ------------------------------------------------------------------
`ifdef CARD_GAME_MISS_CNT_EN
    logic [7:0] misses_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misses_q <= '0;
        end else if (w_miss_clr) begin
            misses_q <= '0;
        end else if (w_miss_inc && (misses_q != 8'hFF)) begin
            misses_q <= misses_q + 8'd1;
        end
    end

    assign bus.misses = misses_q;
`else
    logic w_unused_miss;
    assign w_unused_miss = w_miss_inc | w_miss_clr;
    assign bus.misses    = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.qval    = qval_q;
    assign bus.cursor  = w_cursor;
    assign bus.face_up = face_up_q;
    assign bus.matched = matched_q;
    assign bus.pairs   = pairs_q;
    assign bus.playing = playing_q;
    assign bus.win     = win_q;

endmodule
`default_nettype wire

// File: tb/tb_card_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_game_ctrl
//  Description : Directed self-checking bench for card_game_ctrl with
//                SHOW_FRAMES = 2. Expected miss counts follow
//                CARD_GAME_MISS_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_game_ctrl;

`ifdef CARD_GAME_MISS_CNT_EN
    localparam int c_miss_en = 1;
`else
    localparam int c_miss_en = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    card_game_if bus ();

    card_game_ctrl #(.SHOW_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cur      = 0;

    logic [2:0]  lay [16] = '{3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd4,
                              3'd6, 3'd0, 3'd4, 3'd1, 3'd7, 3'd3, 3'd5, 3'd2};
    logic [52:0] all_out;

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btns();
        bus.btn_sel    = 1'b0;
        bus.btn_up     = 1'b0;
        bus.btn_down   = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    // 0 sel, 1 up, 2 down, 3 left, 4 right, other: frame tick
    task automatic press(input int b);
        case (b)
            0:       bus.btn_sel   = 1'b1;
            1:       bus.btn_up    = 1'b1;
            2:       bus.btn_down  = 1'b1;
            3:       bus.btn_left  = 1'b1;
            4:       bus.btn_right = 1'b1;
            default: bus.frame_tick = 1'b1;
        endcase
        step();
        clear_btns();
    endtask

    task automatic goto(input int pos);
        int dr;
        int dc;
        dr = ((pos / 4) - (cur / 4) + 4) % 4;
        dc = ((pos % 4) - (cur % 4) + 4) % 4;
        repeat (dr) press(2);
        repeat (dc) press(4);
        cur = pos;
    endtask

    task automatic pick(input int a, input int b);
        goto(a);
        press(0);
        goto(b);
        press(0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        all_out = {bus.cursor, bus.face_up, bus.matched, bus.pairs, bus.misses,
                   bus.qval, bus.playing, bus.win};
        n_checks++;
        if (all_out !== 53'd0) begin
            n_fails++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
        // Release reset and select in the same cycle: seed latches 0.
        rst_n       = 1'b1;
        bus.btn_sel = 1'b1;
        step();
        clear_btns();
        cur = 0;
        n_checks++;
        if (bus.playing !== 1'b1 || bus.win !== 1'b0) begin
            n_fails++;
            $display("FAIL start_playing got playing=%b win=%b want 1 0", bus.playing, bus.win);
        end
        for (int p = 0; p < 16; p++) begin
            bus.qpos = 4'(p);
            step();
            n_checks++;
            if (bus.qval !== lay[p]) begin
                n_fails++;
                $display("FAIL qval_seed0 pos=%0d got %0d want %0d", p, bus.qval, lay[p]);
            end
        end
    endtask

    task automatic test_cursor_wrap();
        press(3);
        n_checks++;
        if (bus.cursor !== 4'd3) begin
            n_fails++;
            $display("FAIL wrap_left got %0d want 3", bus.cursor);
        end
        press(1);
        n_checks++;
        if (bus.cursor !== 4'd15) begin
            n_fails++;
            $display("FAIL wrap_up got %0d want 15", bus.cursor);
        end
        cur = 15;
    endtask

    task automatic test_mismatch();
        pick(0, 1);
        n_checks++;
        if (bus.face_up !== 16'h0003) begin
            n_fails++;
            $display("FAIL mis_reveal face_up got %h want 0003", bus.face_up);
        end
        press(5);
        n_checks++;
        if (bus.face_up !== 16'h0003) begin
            n_fails++;
            $display("FAIL mis_hold face_up got %h want 0003", bus.face_up);
        end
        press(5);
        n_checks++;
        if (bus.face_up !== 16'h0000 || bus.matched !== 16'h0000) begin
            n_fails++;
            $display("FAIL mis_resolve face_up=%h matched=%h want 0000 0000", bus.face_up, bus.matched);
        end
        n_checks++;
        if (bus.misses !== 8'(c_miss_en) || bus.playing !== 1'b1) begin
            n_fails++;
            $display("FAIL mis_count misses=%0d playing=%b want %0d 1", bus.misses, bus.playing, c_miss_en);
        end
    endtask

    task automatic test_match();
        pick(0, 13);
        n_checks++;
        if (bus.face_up !== 16'h2001) begin
            n_fails++;
            $display("FAIL match_reveal face_up got %h want 2001", bus.face_up);
        end
        press(5);
        press(5);
        n_checks++;
        if (bus.matched !== 16'h2001 || bus.face_up !== 16'h0000) begin
            n_fails++;
            $display("FAIL match_masks matched=%h face_up=%h want 2001 0000", bus.matched, bus.face_up);
        end
        n_checks++;
        if (bus.pairs !== 4'd1 || bus.misses !== 8'(c_miss_en)) begin
            n_fails++;
            $display("FAIL match_counts pairs=%0d misses=%0d want 1 %0d", bus.pairs, bus.misses, c_miss_en);
        end
    endtask

    task automatic test_ignored_select();
        goto(2);
        press(0);
        press(0);           // first card again: ignored
        goto(13);
        press(0);           // matched card: ignored
        n_checks++;
        if (bus.face_up !== 16'h0004 || bus.playing !== 1'b1) begin
            n_fails++;
            $display("FAIL ignore_sel face_up=%h playing=%b want 0004 1", bus.face_up, bus.playing);
        end
        press(5);           // tick outside SHOW does nothing
        goto(9);
        bus.btn_sel   = 1'b1;
        bus.btn_right = 1'b1;
        step();
        clear_btns();
        n_checks++;
        if (bus.cursor !== 4'd9) begin
            n_fails++;
            $display("FAIL sel_priority cursor got %0d want 9", bus.cursor);
        end
        n_checks++;
        if (bus.face_up !== 16'h0204) begin
            n_fails++;
            $display("FAIL sel_priority face_up got %h want 0204", bus.face_up);
        end
        press(5);
        press(5);
        n_checks++;
        if (bus.matched !== 16'h2205 || bus.pairs !== 4'd2) begin
            n_fails++;
            $display("FAIL second_pair matched=%h pairs=%0d want 2205 2", bus.matched, bus.pairs);
        end
    endtask

    task automatic test_win();
        int pa [6] = '{1, 3, 4, 5, 6, 7};
        int pb [6] = '{14, 12, 11, 8, 15, 10};
        for (int i = 0; i < 6; i++) begin
            pick(pa[i], pb[i]);
            press(5);
            n_checks++;
            if (bus.win !== 1'b0) begin
                n_fails++;
                $display("FAIL win_early pair=%0d got win=%b want 0", i, bus.win);
            end
            press(5);
            n_checks++;
            if (bus.pairs !== 4'(i + 3)) begin
                n_fails++;
                $display("FAIL pair_count got %0d want %0d", bus.pairs, i + 3);
            end
        end
        n_checks++;
        if (bus.win !== 1'b1 || bus.playing !== 1'b0 || bus.matched !== 16'hFFFF) begin
            n_fails++;
            $display("FAIL win_state win=%b playing=%b matched=%h want 1 0 ffff", bus.win, bus.playing, bus.matched);
        end
        press(3);           // cursor frozen in WIN
        n_checks++;
        if (bus.cursor !== 4'd10) begin
            n_fails++;
            $display("FAIL win_cursor_frozen got %0d want 10", bus.cursor);
        end
        press(0);
        cur = 0;
        all_out = {bus.cursor, bus.face_up, bus.matched, bus.pairs, bus.misses,
                   bus.qval, bus.playing, bus.win};
        n_checks++;
        if (all_out[52:5] !== 48'd0 || all_out[1:0] !== 2'b00) begin
            n_fails++;
            $display("FAIL win_to_idle got %h want zero masks/counters/flags", all_out);
        end
        press(4);           // ignored in IDLE
        n_checks++;
        if (bus.cursor !== 4'd0 || bus.playing !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_ignore cursor=%0d playing=%b want 0 0", bus.cursor, bus.playing);
        end
    endtask

    task automatic test_reset_mid_game();
        press(0);
        pick(0, 1);
        n_checks++;
        if (bus.face_up !== 16'h0003 || bus.playing !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_show face_up=%h playing=%b want 0003 1", bus.face_up, bus.playing);
        end
        rst_n = 1'b0;
        step();
        all_out = {bus.cursor, bus.face_up, bus.matched, bus.pairs, bus.misses,
                   bus.qval, bus.playing, bus.win};
        n_checks++;
        if (all_out !== 53'd0) begin
            n_fails++;
            $display("FAIL mid_reset got %h want 0", all_out);
        end
        rst_n       = 1'b1;
        bus.btn_sel = 1'b1;
        step();
        clear_btns();
        cur = 0;
        for (int i = 0; i < 3; i++) begin
            pick(0, 1);
            press(5);
            press(5);
        end
        n_checks++;
        if (bus.misses !== 8'(3 * c_miss_en) || bus.face_up !== 16'h0000) begin
            n_fails++;
            $display("FAIL three_misses misses=%0d face_up=%h want %0d 0000", bus.misses, bus.face_up, 3 * c_miss_en);
        end
    endtask

    initial begin
        bus.qpos = 4'd0;
        clear_btns();
        test_reset();
        test_cursor_wrap();
        test_mismatch();
        test_match();
        test_ignored_select();
        test_win();
        test_reset_mid_game();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/card_game_ctrl.md
# card_game_ctrl

Game controller for the 4x4 card-matching display. Owns the board state: card layout, cursor, face-up and matched masks, pair and miss counters. Sequences a turn from the first pick through the second pick, a timed reveal and the compare. Sits between the debounced button logic and the per-position card renderers, which read `face_up`, `matched`, `cursor` and the query port.

## Interface
- `SHOW_FRAMES`, default 60: `frame_tick` pulses a mismatched pair stays visible; legal range 1..255.
- `clk` in 1: system/pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel` in 1 each: debounced one-cycle pulses.
- `qpos` in 4: renderer query position.
- `qval` out 3: card value at `qpos`, registered.
- `cursor` out 4: `[3:2]` row, `[1:0]` column; position 0 is top-left, row-major.
- `face_up` out 16: cards currently revealed in the turn.
- `matched` out 16: cards permanently solved.
- `pairs` out 4: matched pair count, 0..8.
- `misses` out 8: mismatch count, saturating.
- `playing` out 1: high in PICK1, PICK2 and SHOW.
- `win` out 1: high in WIN.

## Operation
- Reset values: state IDLE, `cursor`=0, `face_up`=0, `matched`=0, `pairs`=0, `misses`=0, `qval`=0, `playing`=0, `win`=0, `seed`=0, `first`=0, `second`=0, `fcnt`=0. Asserting reset mid-game returns everything to these values on the next edge.
- Seed counter: 4-bit, free-running. It is 0 in the first cycle after `rst_n` rises and increments every cycle.
- Layout: `value(p) = LAYOUT[p ^ seed]`, with LAYOUT = 3,5,0,7,1,6,2,4,6,0,4,1,7,3,5,2. XOR with the seed is a bijection, so every value still occurs exactly twice.
- Input priority: at most one button acts per cycle, in the order sel > up > down > left > right.
- Cursor moves only in PICK1 and PICK2. Moves wrap within the row or column: left from column 0 goes to column 3; up from row 0 goes to row 3.
- A selectable card has `face_up[cursor]`=0 and `matched[cursor]`=0.
- IDLE:
  - `btn_sel` latches the seed counter into `seed` and moves to PICK1.
  - All other buttons are ignored.
- PICK1: `btn_sel` on a selectable card sets `face_up[cursor]`, stores `first`=cursor and moves to PICK2. Otherwise `btn_sel` is ignored.
- PICK2: `btn_sel` on a selectable card sets `face_up[cursor]`, stores `second`, clears `fcnt` and moves to SHOW. Selecting `first` again is ignored because it is already face up.
- SHOW:
  - Buttons are ignored.
  - Each `frame_tick` increments `fcnt`.
  - On the tick that makes `fcnt`=SHOW_FRAMES, resolve the pair:
    - Equal values: set `matched` for both cards, clear both `face_up` bits, increment `pairs`. Go to WIN if `pairs` becomes 8, else to PICK1.
    - Unequal values: clear both `face_up` bits, increment `misses` (saturating at 255), go to PICK1.
- WIN: `btn_sel` clears `face_up`, `matched`, `pairs`, `misses` and `cursor`, then goes to IDLE.

## Timing
- Every output is registered. A button sampled on edge N is reflected in the outputs after edge N.
- Query latency: `qval` reflects `qpos` with one cycle of latency. The renderer already registers its pixel by one cycle, so it must present `qpos` one pixel early.
- SHOW duration: exactly SHOW_FRAMES ticks. A tick in the same cycle as the second `btn_sel` is not counted.
- Resolve edge: `matched`/`face_up`/`pairs`/`misses` and the state all update on the same edge.
- `win` rises on the edge where `pairs` reaches 8.

## Configuration
- `CARD_GAME_MISS_CNT_EN`:
  - Defined: the `misses` counter is built and saturates at 255.
  - Undefined: no counter is built and `misses` is tied to 0.
  - All other behaviour is identical either way.

## Structure
- `card_game_pkg` holds:
  - the state enum: IDLE, PICK1, PICK2, SHOW, WIN;
  - the LAYOUT constant;
  - `NUM_PAIRS`=8 and `GRID`=4.
- One sub-module, `card_cursor`, holds the cursor register plus wrap logic. Its inputs are the four direction pulses and an enable; its output is `cursor`.

## Test plan
- Reset, then `btn_sel` in the first cycle after release: `seed`=0, state PICK1, `playing`=1. Then `btn_left`: `cursor`=3. Then `btn_up`: `cursor`=15.
- Seed 0, SHOW_FRAMES=2: select positions 0 and 13 (both value 3). After 2 ticks: `matched`=0x2001, `face_up`=0, `pairs`=1, `misses`=0.
- Seed 0: select positions 0 and 1 (values 3 and 5). `face_up`=0x0003 holds for exactly SHOW_FRAMES ticks, then `face_up`=0, `misses`=1, state PICK1.
- In PICK2 with `first`=0, press `btn_sel` on position 0, then on matched position 13: no state change. Pressing `btn_sel` and `btn_right` in the same cycle: the select acts, the cursor does not move.
- Solve all 8 pairs: `win`=1 on the edge `pairs` reaches 8. Then `btn_sel` returns to IDLE with all masks and counters at 0.
- Assert `rst_n`=0 during SHOW: all outputs return to reset values on the next edge. With `CARD_GAME_MISS_CNT_EN` undefined, `misses` stays 0 after 3 mismatches.
